bin2bcd_conv: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3). Sits directly upstream of the
//   4-digit 7-segment mux driver. Accepts a binary count (e.g. lift floor or load value)

---
 rtl/bin2bcd_pkg.sv | 8 +
 rtl/bin2bcd_conv_digit_adj.sv | 12 +
 rtl/bin2bcd_conv.sv | 108 ++++++++++
 tb/tb_bin2bcd_conv.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OVF_NIBBLE = 4'hE;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;
endpackage

// File: rtl/bin2bcd_conv_digit_adj.sv
// Per-digit add-3 correction applied before each shift of the BCD register.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  // Nibbles >= 5 would carry past 9 after doubling, so pre-bias by 3 (4-bit wrap)
  always_comb begin
    o_nib = (i_nib >= ADJ_THRESH) ? (i_nib + ADJ_ADD) : i_nib;
  end
endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential shift-and-add-3 binary to packed BCD converter with valid/ready input
// and a held, registered output word for the 7-segment display mux.
module bin2bcd_conv
  import bin2bcd_pkg::*;
#(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [IN_WIDTH-1:0]   i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [DIGITS*4-1:0]   o_bcd_out,
  output logic                  o_out_valid,
  output logic                  o_ovf,
  output logic                  o_busy
);
  localparam int          BW      = DIGITS * 4;
  localparam int          CNT_W   = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned MAX_VAL = 10**DIGITS - 1;

  state_t                r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [IN_WIDTH-1:0]   r_bin_sr;
  logic [BW-1:0]         r_bcd_sr;
  logic                  r_ovf_pend;
  logic [BW-1:0]         r_bcd_out;
  logic                  r_ovf;
  logic                  r_out_valid;

  logic [BW-1:0]          w_bcd_adj;
  logic [BW+IN_WIDTH-1:0] w_shift;
  logic                   w_in_ovf;

  // Add-3 correction on every digit of the running BCD value
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_nib (r_bcd_sr[4*g +: 4]),
      .o_nib (w_bcd_adj[4*g +: 4])
    );
  end

  // Joint left shift; the MSB of the BCD field falls off the top
  assign w_shift  = {w_bcd_adj, r_bin_sr} << 1;
  assign w_in_ovf = 64'(i_in_data) > 64'(MAX_VAL);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic: IDLE -> SHIFT on accept, IN_WIDTH shifts, one DONE cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_in_valid) w_next = SHIFT;
      SHIFT:   if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake and status decode from state
  always_comb begin
    o_in_ready = (r_state == IDLE);
    o_busy     = (r_state == SHIFT) || (r_state == DONE);
  end

  // Datapath: capture, shift, and publish result; outputs hold between DONEs
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt       <= '0;
      r_bin_sr    <= '0;
      r_bcd_sr    <= '0;
      r_ovf_pend  <= 1'b0;
      r_bcd_out   <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: if (i_in_valid) begin
          r_bin_sr   <= i_in_data;
          r_bcd_sr   <= '0;
          r_cnt      <= CNT_W'(IN_WIDTH - 1);
          r_ovf_pend <= w_in_ovf;
        end
        SHIFT: begin
          r_bcd_sr <= w_shift[BW+IN_WIDTH-1:IN_WIDTH];
          r_bin_sr <= w_shift[IN_WIDTH-1:0];
          r_cnt    <= r_cnt - 1'b1;
        end
        DONE: begin
          r_bcd_out   <= r_ovf_pend ? {DIGITS{OVF_NIBBLE}} : r_bcd_sr;
          r_ovf       <= r_ovf_pend;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_bcd_out   = r_bcd_out;
  assign o_ovf       = r_ovf;
  assign o_out_valid = r_out_valid;
endmodule

// File: tb/tb_bin2bcd_conv.sv
// Self-checking bench: cycle-level behavioural model plus directed and random conversions.
module tb_bin2bcd_conv;
  localparam int IN_WIDTH = 14;
  localparam int DIGITS   = 4;
  localparam int LAT      = IN_WIDTH + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [IN_WIDTH-1:0] in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready, out_valid, ovf, busy;
  logic [15:0]         bcd_out;

  int checks = 0;
  int errors = 0;

  bin2bcd_conv #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_in_data(in_data), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .o_bcd_out(bcd_out), .o_out_valid(out_valid),
    .o_ovf(ovf), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    int p;
    r = '0;
    if (v > 9999) return 16'hEEEE;
    p = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a busy countdown and the value the display must show
  int          m_left = 0;
  logic        m_ov = 0, m_ovf = 0, m_povf = 0, armed = 0;
  logic [15:0] m_bcd = '0, m_pbcd = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_ov = 0; m_bcd = '0; m_ovf = 0; armed = 1;
    end else begin
      m_ov = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_ov = 1; m_bcd = m_pbcd; m_ovf = m_povf;
        end
      end else if (in_valid) begin
        m_left = LAT;
        m_pbcd = to_bcd(int'(in_data));
        m_povf = (int'(in_data) > 9999);
      end
    end
  end

  // Compare every cycle once reset has been seen
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(m_left == 0));
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (!ovf)
        for (int d = 0; d < DIGITS; d++) chk("nibble_range", 32'(bcd_out[4*d +: 4] > 4'd9), 0);
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) chk("ready_timeout", 32'(in_ready), 1);
  endtask

  // One conversion with literal expectations for result, latency and ready-low time
  task automatic convert(int v, logic [15:0] exp_bcd, logic exp_ovf);
    int lat, low;
    @(negedge clk);
    wait_ready();
    in_data = IN_WIDTH'(v); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    low = in_ready ? 0 : 1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk); lat++;
      if (!in_ready) low++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    chk("ready_low", 32'(low), 32'(LAT));
    chk("res_bcd", 32'(bcd_out), 32'(exp_bcd));
    chk("res_ovf", 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, pulses, v;
    repeat (3) @(negedge clk);
    chk("reset_bcd", 32'(bcd_out), 0);
    chk("reset_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    // basic conversion and hold
    convert(1234, 16'h1234, 0);
    repeat (5) @(negedge clk);
    chk("hold_bcd", 32'(bcd_out), 32'h1234);

    // back-to-back, boundaries
    convert(0, 16'h0000, 0);
    convert(9999, 16'h9999, 0);
    convert(10000, 16'hEEEE, 1);
    convert(16383, 16'hEEEE, 1);
    convert(5, 16'h0005, 0);
    convert(8191, 16'h8191, 0);

    // in_valid held high with changing data while busy
    @(negedge clk); wait_ready();
    in_data = 14'd1500; in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      in_data = IN_WIDTH'($urandom_range(0, 16383));
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    chk("held_bcd", 32'(bcd_out), 32'h1500);
    chk("held_ovf", 32'(ovf), 0);

    // reset mid-conversion
    @(negedge clk); wait_ready();
    in_data = 14'd4321; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", 32'(in_ready), 1);
    chk("abort_bcd", 32'(bcd_out), 0);
    pulses = 0;
    repeat (20) begin @(negedge clk); if (out_valid) pulses++; end
    chk("abort_no_pulse", 32'(pulses), 0);
    convert(42, 16'h0042, 0);

    // random sweep against the model
    for (int i = 0; i < 300; i++) begin
      v = $urandom_range(0, 16383);
      if (i % 10 == 0) v = $urandom_range(9990, 10010);
      convert(v, to_bcd(v), v > 9999);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
